// File: rtl/io_page_controller.sv
// io_page_controller
// Sits between the processor memory bus and the RAM block and owns the IO page.
// Accesses with mem_addr[IO_PAGE_BIT] set go to the memory-mapped IO registers;
// all others are forwarded to RAM. Read data from either source comes back on
// mem_rdata one cycle after mem_rstrb.
//
// IO word offsets (one-hot in mem_addr[4:2]):
//   bit2 LEDS      : write leds (needs wmask[0]), read {27'b0, leds}
//   bit3 UART_DAT  : write starts a serial frame if idle, else sets overrun; reads 0
//   bit4 UART_CNTL : read bit9 = busy, bit10 = overrun (read clears overrun)
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   mem_addr/wdata/wmask/rstrb processor bus request
//   mem_rdata                  read data to processor
//   ram_rstrb/ram_wmask        strobes forwarded to RAM (suppressed for IO)
//   ram_rdata                  registered RAM read data
//   leds                       LED register
//   uart_txd                   serial output, idle high
module io_page_controller #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int IO_PAGE_BIT = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        ram_rstrb,
  output logic [3:0]  ram_wmask,
  input  logic [31:0] ram_rdata,
  output logic [4:0]  leds,
  output logic        uart_txd
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  tx_state_t state, state_next;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic          overrun;
  logic          busy;
  logic [31:0]   io_rdata;
  logic          is_io_q;
  logic [31:0]   read_value;

  logic is_io, sel_leds, sel_dat, sel_cntl;
  logic io_write, io_read;
  logic tx_accept, tx_reject, bit_done, frame_done;

  // Only a few address/data bits matter to this block.
  logic unused_bits;
  assign unused_bits = ^{mem_addr, mem_wdata};

  assign is_io    = mem_addr[IO_PAGE_BIT];
  assign sel_leds = mem_addr[2];
  assign sel_dat  = mem_addr[3];
  assign sel_cntl = mem_addr[4];

  assign io_write = is_io & (|mem_wmask);
  assign io_read  = is_io & mem_rstrb;

  assign ram_rstrb = mem_rstrb & ~is_io;
  assign ram_wmask = is_io ? 4'b0000 : mem_wmask;

  // A data write is only taken while idle; one that arrives while a frame is
  // still in flight (including the edge the stop bit ends) is dropped.
  assign tx_accept  = io_write & sel_dat & (state == TX_IDLE);
  assign tx_reject  = io_write & sel_dat & (state != TX_IDLE);
  assign bit_done   = (state == TX_SHIFT) && (baud_cnt == '0);
  assign frame_done = bit_done && (bit_cnt == 4'd9);

  // TX state register
  always_ff @(posedge clk) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_next;
  end

  // TX next-state logic
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (tx_accept)  state_next = TX_SHIFT;
      TX_SHIFT: if (frame_done) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // TX outputs
  always_comb begin
    busy     = (state != TX_IDLE);
    uart_txd = (state == TX_SHIFT) ? shift[0] : 1'b1;
  end

  // Baud counter and frame shifter. The reload happens on the same edge the
  // shifter advances, so every bit is held for exactly DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shift    <= 10'h3FF;
    end else if (tx_accept) begin
      baud_cnt <= BAUD_RELOAD;
      bit_cnt  <= 4'd0;
      shift    <= {1'b1, mem_wdata[7:0], 1'b0};
    end else if (state == TX_SHIFT) begin
      if (bit_done) begin
        baud_cnt <= BAUD_RELOAD;
        bit_cnt  <= bit_cnt + 4'd1;
        shift    <= {1'b1, shift[9:1]};
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

  // Overrun: a rejected write wins over a clearing status read on the same edge.
  always_ff @(posedge clk) begin
    if (reset)                     overrun <= 1'b0;
    else if (tx_reject)            overrun <= 1'b1;
    else if (io_read && sel_cntl)  overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      leds <= 5'd0;
    else if (io_write && sel_leds && mem_wmask[0])
      leds <= mem_wdata[4:0];
  end

  // Several one-hot select bits may be set at once; their values are OR-ed.
  always_comb begin
    read_value = 32'd0;
    if (sel_leds) read_value = read_value | {27'd0, leds};
    if (sel_cntl) read_value = read_value | {21'd0, overrun, busy, 9'd0};
  end

  // Read path register; the source select is captured on every read strobe so
  // that it lines up with RAM's one-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_rdata <= 32'd0;
      is_io_q  <= 1'b0;
    end else if (mem_rstrb) begin
      is_io_q <= is_io;
      if (is_io) io_rdata <= read_value;
    end
  end

  assign mem_rdata = is_io_q ? io_rdata : ram_rdata;

endmodule
